// File: rtl/seg_pkg.sv
// Shared constants and hex-to-segment glyph table for the seven-segment display.
// Latency: none (constants and a pure function).
// Backpressure: none.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g; b and d are lowercase.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_OFF;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex nibble to active-low seven-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup shared with every other display user.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with per-digit blink and dp; SEG_SCAN_LZ_BLANK_EN adds leading-zero blanking.
// Latency: outputs registered, 1 cycle after an index/phase change; data snapshotted once per frame.
// Backpressure: none; en=0 darkens the display and freezes all counters.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        blink_phase,
  output logic        frame_start
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0]           ref_cnt;
  logic [BW-1:0]           blink_cnt;
  logic [1:0]              idx;
  logic [15:0]             sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    loaded;

  logic                    ref_tc;
  logic                    blink_tc;
  logic                    wrap;
  logic                    snap;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    digit_off;
  logic [6:0]              seg_next;
  logic                    dp_next;

  assign ref_tc   = (ref_cnt == RW'(REFRESH_DIV - 1));
  assign blink_tc = (blink_cnt == BW'(BLINK_DIV - 1));
  assign wrap     = en && ref_tc && (idx == 2'd3);
  // Snapshot on every frame wrap, and on the very first enabled cycle so the display
  // does not sit on reset data for a whole frame.
  assign snap     = en && (wrap || !loaded);

  // Refresh counter and digit index; both freeze while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
    end else if (en) begin
      if (ref_tc) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end

  // Blink counter and phase, free of any coupling to the refresh counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (en) begin
      if (blink_tc) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Shadow registers: displayed data only changes at frame boundaries so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_value    <= '0;
      sh_dp       <= '0;
      sh_blink    <= '0;
      loaded      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (snap) begin
        sh_value <= value;
        sh_dp    <= dp_mask;
        sh_blink <= blink_mask;
        loaded   <= 1'b1;
      end
    end
  end

  assign cur_nib = sh_value[{idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Leading-zero mask: a digit blanks only if it and every higher digit hold zero; digit 0 never blanks.
  always_comb begin
    lz_blank = '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz_blank[3] = (sh_value[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (sh_value[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (sh_value[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
`endif
  end

  // Per-digit blink gate and dp; the anode stays on so a blanked digit never changes ghosting.
  always_comb begin
    digit_off = sh_blink[idx] && !blink_phase;
    seg_next  = (digit_off || lz_blank[idx]) ? SEG_OFF : dec_seg;
    dp_next   = digit_off ? 1'b1 : ~sh_dp[idx];
  end

  // Registered pin drivers; dark whenever en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (en) begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_next;
      dp  <= dp_next;
    end else begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed literal checks plus a cycle-accurate model under random stimulus.
// Latency: model predicts every output one edge after the state it depends on.
// Backpressure: none.
module tb_seg_scan_ctrl;

  localparam int R = 4;
  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        blink_phase;
  logic        frame_start;

  int checks = 0;
  int passes = 0;

  seg_scan_ctrl #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .value       (value),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .blink_phase (blink_phase),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Glyphs described by which segments are lit, then turned into an active-low bit pattern.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    string s;
    logic [6:0] r;
    case (n)
      4'h0: s = "abcdef";  4'h1: s = "bc";     4'h2: s = "abdeg";  4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";  4'h6: s = "acdefg"; 4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg"; 4'hA: s = "abcefg"; 4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";  4'hE: s = "adefg";  default: s = "aefg";
    endcase
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      int k;
      k = s[i] - 8'h61;
      r[k] = 1'b0;
    end
    return r;
  endfunction

  // Model: the whole scan is a function of E, the number of enabled cycles since reset.
  initial begin
    int          E;
    logic        loaded;
    logic [15:0] sv;
    logic [3:0]  sdp, sbl;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_bp, e_fs;
    E = 0; loaded = 1'b0; sv = '0; sdp = '0; sbl = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        E = 0; loaded = 1'b0; sv = '0; sdp = '0; sbl = '0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
      end else if (!en) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
      end else begin
        int d;
        logic ph, off, lzb;
        logic [3:0] nib;
        d   = (E / R) % 4;
        ph  = ((E / B) % 2) == 0;
        nib = 4'((sv >> (4 * d)) & 16'h000F);
        off = sbl[d] && !ph;
`ifdef SEG_SCAN_LZ_BLANK_EN
        lzb = (d > 0) && ((sv >> (4 * d)) == 16'h0000);
`else
        lzb = 1'b0;
`endif
        e_an  = 4'hF ^ (4'b0001 << d);
        e_seg = (off || lzb) ? 7'h7F : glyph(nib);
        e_dp  = off ? 1'b1 : !dp_mask_sh(sdp, d);
        E++;
        e_fs = (E % (4 * R)) == 0;
        if (!loaded || e_fs) begin
          sv = value; sdp = dp_mask; sbl = blink_mask; loaded = 1'b1;
        end
      end
      e_bp = ((E / B) % 2) == 0;
      #1;
      check("an", {12'h0, an}, {12'h0, e_an});
      check("seg", {9'h0, seg}, {9'h0, e_seg});
      check("dp", {15'h0, dp}, {15'h0, e_dp});
      check("blink_phase", {15'h0, blink_phase}, {15'h0, e_bp});
      check("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
    end
  end

  function automatic logic dp_mask_sh(input logic [3:0] m, input int d);
    return m[d];
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; value = '0; dp_mask = '0; blink_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_seg", {9'h0, seg}, 16'h007F);
    check("rst_dp", {15'h0, dp}, 16'h0001);
    check("rst_bp", {15'h0, blink_phase}, 16'h0001);
    check("rst_fs", {15'h0, frame_start}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; value = 16'h1234;
    repeat (2) @(posedge clk); #1;
    check("lit_an_d0", {12'h0, an}, 16'h000E);
    check("lit_seg_4", {9'h0, seg}, 16'h0019);
    repeat (4) @(posedge clk); #1;
    check("lit_an_d1", {12'h0, an}, 16'h000D);
    check("lit_seg_3", {9'h0, seg}, 16'h0030);
    repeat (4) @(posedge clk); #1;
    check("lit_an_d2", {12'h0, an}, 16'h000B);
    check("lit_seg_2", {9'h0, seg}, 16'h0024);
    repeat (4) @(posedge clk); #1;
    check("lit_an_d3", {12'h0, an}, 16'h0007);
    check("lit_seg_1", {9'h0, seg}, 16'h0079);
    repeat (2) @(posedge clk); #1;
    check("lit_frame_start", {15'h0, frame_start}, 16'h0001);

    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check("lit_dark_an", {12'h0, an}, 16'h000F);
    check("lit_dark_seg", {9'h0, seg}, 16'h007F);
    check("lit_dark_dp", {15'h0, dp}, 16'h0001);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom % 700) != 0;
      en    = ($urandom % 8) != 0;
      if (($urandom % 20) == 0) begin
        value = 16'($urandom);
        case ($urandom % 5)
          0: value = value & 16'h00FF;
          1: value = value & 16'h000F;
          2: value = 16'h0000;
          3: value = 16'h0050;
          default: ;
        endcase
      end
      if (($urandom % 60) == 0) dp_mask = 4'($urandom);
      if (($urandom % 60) == 0) blink_mask = 4'($urandom);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
